// File: rtl/cache_control.sv
// Cache controller FSM: hit/miss handling, dirty writeback, line fill and read-settle delay.
// Optional performance counters are built only when CACHE_CTRL_PERF_EN is defined.

package cache_types;
  typedef enum logic {WAY_HIT = 1'b0, WAY_LRU = 1'b1} waymux_t;
  typedef enum logic {DATA_CPU = 1'b0, DATA_PMEM = 1'b1} datamux_t;
  typedef enum logic {PMAD_REQ = 1'b0, PMAD_LRU = 1'b1} pmadmux_t;
endpackage

module cache_control #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read,
  input  logic                  mem_write,
  output logic                  mem_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  input  logic                  pmem_resp,
  input  logic                  SIGHIT,
  input  logic                  SIGDIRTY,
  output logic                  LD_VALID,
  output logic                  LD_DIRTY,
  output logic                  LD_TAG,
  output logic                  LD_DATA,
  output logic                  LD_PLRU,
  output logic                  DIRTYVAL,
  output cache_types::waymux_t  DIRTYWMUX,
  output cache_types::waymux_t  DATAWMUX,
  output cache_types::datamux_t DATAMUX,
  output cache_types::pmadmux_t PMADMUX,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count,
  output logic [31:0]           wb_count
);
  import cache_types::*;

  typedef enum logic [2:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE, SETTLE} state_t;

  localparam logic [1:0] SETTLE_LOAD = 2'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [1:0] settle_cnt;
  logic       req;

  assign req = mem_read | mem_write;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      settle_cnt <= '0;
    end else begin
      case (state)
        IDLE:      if (req) state <= COMPARE;
        COMPARE: begin
          if (!req || SIGHIT) state <= IDLE;
          else if (SIGDIRTY)  state <= WRITEBACK;
          else                state <= ALLOCATE;
        end
        WRITEBACK: if (pmem_resp) state <= ALLOCATE;
        ALLOCATE: begin
          if (pmem_resp) begin
            state      <= SETTLE;
            settle_cnt <= SETTLE_LOAD;
          end
        end
        SETTLE: begin
          if (settle_cnt == '0) state <= COMPARE;
          else                  settle_cnt <= settle_cnt - 2'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs depend on the current state and same-cycle inputs (hit, pmem_resp).
  always_comb begin
    mem_resp   = 1'b0;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    LD_VALID   = 1'b0;
    LD_DIRTY   = 1'b0;
    LD_TAG     = 1'b0;
    LD_DATA    = 1'b0;
    LD_PLRU    = 1'b0;
    DIRTYVAL   = 1'b0;
    DIRTYWMUX  = WAY_HIT;
    DATAWMUX   = WAY_HIT;
    DATAMUX    = DATA_CPU;
    PMADMUX    = PMAD_REQ;
    case (state)
      COMPARE: begin
        if (req && SIGHIT) begin
          mem_resp = 1'b1;
          LD_PLRU  = 1'b1;
          if (mem_write) begin
            LD_DATA  = 1'b1;
            LD_DIRTY = 1'b1;
            DIRTYVAL = 1'b1;
          end
        end
      end
      WRITEBACK: begin
        pmem_write = 1'b1;
        PMADMUX    = PMAD_LRU;
      end
      ALLOCATE: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          LD_DATA   = 1'b1;
          DATAWMUX  = WAY_LRU;
          DATAMUX   = DATA_PMEM;
          LD_TAG    = 1'b1;
          LD_VALID  = 1'b1;
          LD_DIRTY  = 1'b1;
          DIRTYWMUX = WAY_LRU;
        end
      end
      default: ;
    endcase
  end

`ifdef CACHE_CTRL_PERF_EN
  logic [31:0] hit_cnt, miss_cnt, wb_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
      wb_cnt   <= '0;
    end else begin
      if (state == COMPARE && req && SIGHIT)  hit_cnt  <= hit_cnt + 32'd1;
      if (state == COMPARE && req && !SIGHIT) miss_cnt <= miss_cnt + 32'd1;
      if (state == WRITEBACK && pmem_resp)    wb_cnt   <= wb_cnt + 32'd1;
    end
  end

  assign hit_count  = hit_cnt;
  assign miss_count = miss_cnt;
  assign wb_count   = wb_cnt;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
  assign wb_count   = '0;
`endif

endmodule

// File: tb/tb_cache_control.sv
// Directed bench for cache_control: one instance with SETTLE_CYCLES=1, one with 4.
// Output vectors are compared as a packed word against hand-built constants.

module tb_cache_control;
  import cache_types::*;

`ifdef CACHE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Bit map of the packed output word (MSB first).
  localparam logic [12:0] B_RESP   = 13'h1000;
  localparam logic [12:0] B_PREAD  = 13'h0800;
  localparam logic [12:0] B_PWRITE = 13'h0400;
  localparam logic [12:0] B_VALID  = 13'h0200;
  localparam logic [12:0] B_DIRTY  = 13'h0100;
  localparam logic [12:0] B_TAG    = 13'h0080;
  localparam logic [12:0] B_DATA   = 13'h0040;
  localparam logic [12:0] B_PLRU   = 13'h0020;
  localparam logic [12:0] B_DVAL   = 13'h0010;
  localparam logic [12:0] B_DWMUX  = 13'h0008;
  localparam logic [12:0] B_WMUX   = 13'h0004;
  localparam logic [12:0] B_DMUX   = 13'h0002;
  localparam logic [12:0] B_PMAD   = 13'h0001;

  localparam logic [12:0] O_NONE  = 13'h0000;
  localparam logic [12:0] O_RHIT  = B_RESP | B_PLRU;
  localparam logic [12:0] O_WHIT  = B_RESP | B_PLRU | B_DATA | B_DIRTY | B_DVAL;
  localparam logic [12:0] O_WB    = B_PWRITE | B_PMAD;
  localparam logic [12:0] O_ALLOC = B_PREAD;
  localparam logic [12:0] O_FILL  = B_PREAD | B_DATA | B_WMUX | B_DMUX | B_TAG | B_VALID
                                  | B_DIRTY | B_DWMUX;

  logic clk = 1'b0;
  logic rst, mem_read, mem_write, pmem_resp, sighit, sigdirty;

  logic mem_resp1, pmem_read1, pmem_write1, ld_valid1, ld_dirty1, ld_tag1, ld_data1, ld_plru1, dirtyval1;
  waymux_t dwmux1, wmux1;
  datamux_t dmux1;
  pmadmux_t pmad1;
  logic [31:0] hits1, misses1, wbs1;

  logic mem_resp4, pmem_read4, pmem_write4, ld_valid4, ld_dirty4, ld_tag4, ld_data4, ld_plru4, dirtyval4;
  waymux_t dwmux4, wmux4;
  datamux_t dmux4;
  pmadmux_t pmad4;
  logic [31:0] hits4, misses4, wbs4;

  logic [12:0] outs1, outs4;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cache_control #(.SETTLE_CYCLES(1)) u1 (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp1),
    .pmem_read(pmem_read1), .pmem_write(pmem_write1), .pmem_resp(pmem_resp),
    .SIGHIT(sighit), .SIGDIRTY(sigdirty),
    .LD_VALID(ld_valid1), .LD_DIRTY(ld_dirty1), .LD_TAG(ld_tag1), .LD_DATA(ld_data1),
    .LD_PLRU(ld_plru1), .DIRTYVAL(dirtyval1), .DIRTYWMUX(dwmux1), .DATAWMUX(wmux1),
    .DATAMUX(dmux1), .PMADMUX(pmad1),
    .hit_count(hits1), .miss_count(misses1), .wb_count(wbs1)
  );

  cache_control #(.SETTLE_CYCLES(4)) u4 (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp4),
    .pmem_read(pmem_read4), .pmem_write(pmem_write4), .pmem_resp(pmem_resp),
    .SIGHIT(sighit), .SIGDIRTY(sigdirty),
    .LD_VALID(ld_valid4), .LD_DIRTY(ld_dirty4), .LD_TAG(ld_tag4), .LD_DATA(ld_data4),
    .LD_PLRU(ld_plru4), .DIRTYVAL(dirtyval4), .DIRTYWMUX(dwmux4), .DATAWMUX(wmux4),
    .DATAMUX(dmux4), .PMADMUX(pmad4),
    .hit_count(hits4), .miss_count(misses4), .wb_count(wbs4)
  );

  assign outs1 = {mem_resp1, pmem_read1, pmem_write1, ld_valid1, ld_dirty1, ld_tag1, ld_data1,
                  ld_plru1, dirtyval1, dwmux1, wmux1, dmux1, pmad1};
  assign outs4 = {mem_resp4, pmem_read4, pmem_write4, ld_valid4, ld_dirty4, ld_tag4, ld_data4,
                  ld_plru4, dirtyval4, dwmux4, wmux4, dmux4, pmad4};

  function automatic logic [31:0] cexp(input int unsigned n);
    return PERF ? 32'(n) : 32'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs, check outputs before the next rising edge, then advance.
  task automatic cyc(input logic mr, input logic mw, input logic hit, input logic dirty,
                     input logic presp, input logic [12:0] exp, input string tag, input bit on4);
    mem_read  = mr;
    mem_write = mw;
    sighit    = hit;
    sigdirty  = dirty;
    pmem_resp = presp;
    #1;
    chk(tag, on4 ? 32'(outs4) : 32'(outs1), 32'(exp));
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; sighit = 1'b0; sigdirty = 1'b0; pmem_resp = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; sighit = 1'b0; sigdirty = 1'b0; pmem_resp = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;

    // Out of reset
    chk("reset_outs1", 32'(outs1), 32'(O_NONE));
    chk("reset_outs4", 32'(outs4), 32'(O_NONE));
    chk("reset_hits", hits1, 32'd0);
    chk("reset_misses", misses1, 32'd0);
    chk("reset_wbs", wbs1, 32'd0);

    // Read hit
    cyc(1, 0, 1, 0, 0, O_NONE, "rhit_idle", 0);
    cyc(1, 0, 1, 0, 0, O_RHIT, "rhit_cmp", 0);
    cyc(0, 0, 0, 0, 0, O_NONE, "rhit_done", 0);
    chk("rhit_hits", hits1, cexp(1));
    chk("rhit_misses", misses1, cexp(0));

    // Clean read miss, pmem_resp on the 5th ALLOCATE cycle
    do_reset();
    cyc(1, 0, 0, 0, 0, O_NONE,  "crm_idle", 0);
    cyc(1, 0, 0, 0, 0, O_NONE,  "crm_cmp", 0);
    cyc(1, 0, 0, 0, 0, O_ALLOC, "crm_alloc1", 0);
    cyc(1, 0, 0, 0, 0, O_ALLOC, "crm_alloc2", 0);
    cyc(1, 0, 0, 0, 0, O_ALLOC, "crm_alloc3", 0);
    cyc(1, 0, 0, 0, 0, O_ALLOC, "crm_alloc4", 0);
    cyc(1, 0, 0, 0, 1, O_FILL,  "crm_fill", 0);
    cyc(1, 0, 1, 0, 0, O_NONE,  "crm_settle", 0);
    cyc(1, 0, 1, 0, 0, O_RHIT,  "crm_hit", 0);
    cyc(0, 0, 0, 0, 0, O_NONE,  "crm_done", 0);
    chk("crm_hits", hits1, cexp(1));
    chk("crm_misses", misses1, cexp(1));
    chk("crm_wbs", wbs1, cexp(0));

    // Dirty write miss
    do_reset();
    cyc(0, 1, 0, 1, 0, O_NONE,  "dwm_idle", 0);
    cyc(0, 1, 0, 1, 0, O_NONE,  "dwm_cmp", 0);
    cyc(0, 1, 0, 1, 0, O_WB,    "dwm_wb1", 0);
    cyc(0, 1, 0, 1, 0, O_WB,    "dwm_wb2", 0);
    cyc(0, 1, 0, 1, 1, O_WB,    "dwm_wb_resp", 0);
    cyc(0, 1, 0, 1, 0, O_ALLOC, "dwm_alloc", 0);
    cyc(0, 1, 0, 1, 1, O_FILL,  "dwm_fill", 0);
    cyc(0, 1, 1, 0, 0, O_NONE,  "dwm_settle", 0);
    cyc(0, 1, 1, 0, 0, O_WHIT,  "dwm_hit", 0);
    cyc(0, 0, 0, 0, 0, O_NONE,  "dwm_done", 0);
    chk("dwm_hits", hits1, cexp(1));
    chk("dwm_misses", misses1, cexp(1));
    chk("dwm_wbs", wbs1, cexp(1));

    // Read and write together act as a write; stray pmem_resp in IDLE ignored
    do_reset();
    cyc(0, 0, 0, 0, 1, O_NONE, "idle_presp", 0);
    cyc(1, 1, 1, 0, 0, O_NONE, "rw_idle", 0);
    cyc(1, 1, 1, 0, 1, O_WHIT, "rw_cmp", 0);
    // Strobe dropped in COMPARE: no response, back to IDLE
    cyc(1, 0, 1, 0, 0, O_NONE, "drop_idle", 0);
    cyc(0, 0, 1, 0, 0, O_NONE, "drop_cmp", 0);
    cyc(1, 0, 1, 0, 0, O_NONE, "drop_idle2", 0);
    cyc(1, 0, 1, 0, 0, O_RHIT, "drop_hit", 0);
    cyc(0, 0, 0, 0, 0, O_NONE, "drop_done", 0);
    chk("rw_hits", hits1, cexp(2));

    // Reset while ALLOCATE holds pmem_read
    do_reset();
    cyc(1, 0, 0, 0, 0, O_NONE,  "rst_idle", 0);
    cyc(1, 0, 0, 0, 0, O_NONE,  "rst_cmp", 0);
    cyc(1, 0, 0, 0, 0, O_ALLOC, "rst_alloc", 0);
    chk("rst_pre_misses", misses1, cexp(1));
    rst = 1'b0;
    cyc(1, 0, 0, 0, 0, O_ALLOC, "rst_asserted", 0);
    rst = 1'b1;
    cyc(0, 0, 0, 0, 0, O_NONE,  "rst_after", 0);
    chk("rst_misses", misses1, 32'd0);
    chk("rst_hits", hits1, 32'd0);
    cyc(0, 0, 0, 0, 1, O_NONE,  "rst_idle_stay", 0);

    // SETTLE_CYCLES=4 instance: four silent cycles, stray pmem_resp ignored
    do_reset();
    cyc(1, 0, 0, 0, 0, O_NONE, "s4_idle", 1);
    cyc(1, 0, 0, 0, 0, O_NONE, "s4_cmp", 1);
    cyc(1, 0, 0, 0, 1, O_FILL, "s4_fill", 1);
    cyc(1, 0, 1, 0, 0, O_NONE, "s4_settle1", 1);
    cyc(1, 0, 1, 0, 1, O_NONE, "s4_settle2", 1);
    cyc(1, 0, 1, 0, 1, O_NONE, "s4_settle3", 1);
    cyc(1, 0, 1, 0, 0, O_NONE, "s4_settle4", 1);
    cyc(1, 0, 1, 0, 0, O_RHIT, "s4_hit", 1);
    cyc(0, 0, 0, 0, 0, O_NONE, "s4_done", 1);
    chk("s4_hits", hits4, cexp(1));
    chk("s4_misses", misses4, cexp(1));
    chk("s4_wbs", wbs4, cexp(0));

`ifdef CACHE_CTRL_PERF_EN
    // Hit counter wraps from all-ones to zero
    do_reset();
    force u1.hit_cnt = 32'hFFFF_FFFF;
    #1;
    release u1.hit_cnt;
    chk("wrap_preset", hits1, 32'hFFFF_FFFF);
    cyc(1, 0, 1, 0, 0, O_NONE, "wrap_idle", 0);
    cyc(1, 0, 1, 0, 0, O_RHIT, "wrap_cmp", 0);
    cyc(0, 0, 0, 0, 0, O_NONE, "wrap_done", 0);
    chk("wrap_hits", hits1, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
